sys_bus_ctrl_ws: RTL

Registered successor to the combinational system bus control. It arbitrates the memory bus between the CPU and one DMA master, selects the MAB source, and inserts parametrised wait states for FRAM-region accesses. It stalls the CPU during wait states and DMA ownership, and emits a one-cycle memory strobe on the final cycle of each access. It sits between the CPU control unit and the memory/peripheral bus.

---
 rtl/sys_bus_ctrl_ws_pkg.sv | 26 ++
 rtl/sys_bus_ctrl_ws_counter.sv | 36 +++
 rtl/sys_bus_ctrl_ws.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sys_bus_ctrl_ws_pkg.sv
// Shared definitions for the wait-stated system bus controller: FSM encoding,
// CPU address-source select, FRAM defaults and the alignment helper.
package sys_bus_pkg;

  localparam int unsigned FRAM_BASE_DEF = 32'h0000_4000;
  localparam int unsigned FRAM_WS_DEF   = 1;
  localparam int          WS_W          = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } bus_state_e;

  typedef enum logic [1:0] {
    SRC_INT  = 2'd0,
    SRC_PC   = 2'd1,
    SRC_ADDR = 2'd2
  } bus_src_e;

  // A word access must sit on an even address.
  function automatic logic word_misaligned(input logic bw, input logic a0);
    return !bw && a0;
  endfunction

endpackage

// File: rtl/sys_bus_ctrl_ws_counter.sv
// Wait-state counter: loads at an accept edge, counts down while an access
// is stretched, and reports zero both now and after the coming edge.
module bus_ws_counter
  import sys_bus_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [WS_W-1:0] load_val,
  input  logic            dec,
  output logic            zero,
  output logic            zero_next
);

  logic [WS_W-1:0] cnt;
  logic [WS_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt != '0)
      cnt_d = cnt - WS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= cnt_d;
  end

  assign zero      = (cnt == '0);
  assign zero_next = (cnt_d == '0);

endmodule

// File: rtl/sys_bus_ctrl_ws.sv
// Registered CPU/DMA memory bus controller with FRAM wait states.
// Optional macro BUS_ALIGN_CHK_EN: word accesses to odd addresses are forced even and flag bus_err.
module sys_bus_ctrl_ws
  import sys_bus_pkg::*;
#(
  parameter int          ADDR_W        = 16,
  parameter int          DATA_W        = 16,
  parameter logic [ADDR_W-1:0] FRAM_BASE = ADDR_W'(FRAM_BASE_DEF),
  parameter int unsigned FRAM_WS       = FRAM_WS_DEF,
  parameter int          DMA_MAX_BURST = 4
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              INTACK,
  input  logic              IdxF,
  input  logic              IF,
  input  logic              Mem,
  input  logic              Ex,
  input  logic              IW6,
  input  logic              BWin,
  input  logic [ADDR_W-1:0] PCnt,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [ADDR_W-1:0] IntAddr,
  input  logic [DATA_W-1:0] result,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  input  logic              dma_bw,
  output logic [ADDR_W-1:0] MAB,
  output logic [DATA_W-1:0] MDBout,
  output logic              MW,
  output logic              BW,
  output logic              MREQ,
  output logic              MSTB,
  output logic              cpu_stall,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic              bus_err,
  output logic [1:0]        dbg_state
);

  // Handshake: a CPU phase flag or dma_req is a level request sampled only at
  // accept edges (IDLE or the final cycle); dma_req stays high until dma_done.
  // MSTB marks the single cycle in which memory commits or returns data.

  localparam int BURST_W = $clog2(DMA_MAX_BURST + 1);
  localparam logic [BURST_W-1:0] MAX_B     = BURST_W'(DMA_MAX_BURST);
  localparam logic [WS_W-1:0]    FRAM_WS_V = WS_W'(FRAM_WS);

  bus_state_e        state;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_eff;
  logic              acc_err;

  logic              cpu_req;
  bus_src_e          cpu_src;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic              final_cyc;
  logic              accept;
  logic              cpu_wins;
  logic              dma_wins;
  logic [ADDR_W-1:0] nxt_addr;
  logic [ADDR_W-1:0] nxt_mab;
  logic [DATA_W-1:0] nxt_wdata;
  logic              nxt_we;
  logic              nxt_bw;
  logic              misalign;
  logic [WS_W-1:0]   ws_load;
  logic              ws_zero;
  logic              ws_zero_next;

  assign cpu_req = INTACK | IdxF | IF | Mem | Ex;
  assign cpu_we  = Ex & IW6 & ~(INTACK | IdxF | IF | Mem);

  always_comb begin
    cpu_src = SRC_ADDR;
    if (INTACK)
      cpu_src = SRC_INT;
    else if (IdxF || IF)
      cpu_src = SRC_PC;
    case (cpu_src)
      SRC_INT: cpu_addr = IntAddr;
      SRC_PC:  cpu_addr = PCnt;
      default: cpu_addr = Addr;
    endcase
  end

  assign final_cyc = (state != IDLE) && ws_zero;
  assign accept    = (state == IDLE) || final_cyc;

  // Count the DMA access finishing this cycle so the limit bites on time.
  assign burst_eff = (state == DMA_ACC && final_cyc && burst_cnt != MAX_B)
                   ? burst_cnt + BURST_W'(1) : burst_cnt;
  assign cpu_wins  = cpu_req && (!dma_req || burst_eff == MAX_B);
  assign dma_wins  = dma_req && !cpu_wins;

  always_comb begin
    if (dma_wins) begin
      nxt_addr  = dma_addr;
      nxt_wdata = dma_wdata;
      nxt_we    = dma_we;
      nxt_bw    = dma_bw;
    end else begin
      nxt_addr  = cpu_addr;
      nxt_wdata = cpu_we ? result : '0;
      nxt_we    = cpu_we;
      nxt_bw    = BWin;
    end
  end

`ifdef BUS_ALIGN_CHK_EN
  assign misalign = word_misaligned(nxt_bw, nxt_addr[0]);
`else
  assign misalign = 1'b0;
`endif

  assign nxt_mab = misalign ? {nxt_addr[ADDR_W-1:1], 1'b0} : nxt_addr;
  assign ws_load = ((dma_wins || cpu_wins) && nxt_addr >= FRAM_BASE) ? FRAM_WS_V : '0;

  bus_ws_counter u_ws (
    .clk       (MCLK),
    .reset     (reset),
    .load      (accept),
    .load_val  (ws_load),
    .dec       (!accept),
    .zero      (ws_zero),
    .zero_next (ws_zero_next)
  );

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      acc_err   <= 1'b0;
      MAB       <= '0;
      MDBout    <= '0;
      MW        <= 1'b0;
      BW        <= 1'b0;
      MREQ      <= 1'b0;
      MSTB      <= 1'b0;
      cpu_stall <= 1'b0;
      dma_gnt   <= 1'b0;
      dma_done  <= 1'b0;
      bus_err   <= 1'b0;
    end else if (accept) begin
      if (dma_wins || cpu_wins) begin
        state     <= dma_wins ? DMA_ACC : CPU_ACC;
        MAB       <= nxt_mab;
        MDBout    <= nxt_wdata;
        MW        <= nxt_we;
        BW        <= nxt_bw;
        MREQ      <= 1'b1;
        MSTB      <= ws_zero_next;
        cpu_stall <= dma_wins || !ws_zero_next;
        dma_gnt   <= dma_wins;
        dma_done  <= dma_wins && ws_zero_next;
        acc_err   <= misalign;
        bus_err   <= misalign && ws_zero_next;
      end else begin
        state     <= IDLE;
        MW        <= 1'b0;
        MREQ      <= 1'b0;
        MSTB      <= 1'b0;
        cpu_stall <= 1'b0;
        dma_gnt   <= 1'b0;
        dma_done  <= 1'b0;
        acc_err   <= 1'b0;
        bus_err   <= 1'b0;
      end
      if (cpu_wins || !cpu_req)
        burst_cnt <= '0;
      else
        burst_cnt <= burst_eff;
    end else begin
      // Wait cycle: address, data and controls hold; only the strobes move.
      MSTB      <= ws_zero_next;
      cpu_stall <= (state == DMA_ACC) || !ws_zero_next;
      dma_done  <= (state == DMA_ACC) && ws_zero_next;
      bus_err   <= acc_err && ws_zero_next;
      if (!cpu_req)
        burst_cnt <= '0;
    end
  end

  assign dbg_state = state;

endmodule
